// File: rtl/imem_pkg.sv
// Shared types and constants for the pipelined instruction memory.
package imem_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int unsigned NOP_WORD = 0;

endpackage

// File: rtl/imem_ram.sv
// Single-port-write, registered-read instruction storage.
module imem_ram #(
    parameter int N     = 32,
    parameter int DEPTH = 64,
    parameter int CW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [CW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic          re,
    input  logic [CW-1:0] raddr,
    output logic [N-1:0]  rdata
);

    logic [N-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto RAM macros; the owner zeroes it by sweeping writes.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The read register is a plain flop and does reset, so the response reads 0 during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            // NOTE: non-blocking assignment for every sequential register.
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_pipe.sv
// Instruction memory with clear/load/run control and a one-deep response stage.
module imem_pipe
    import imem_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 64,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load_mode,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [N-1:0]  wr_data,
    output logic          wr_err,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic          flush,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [N-1:0]  rsp_data,
    output logic          rsp_fault,
    output logic          busy
);

    localparam int CW = $clog2(DEPTH);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          wr_in_range, req_in_range;
    logic          load_wr, accept;
    logic          ram_we;
    logic [CW-1:0] ram_waddr;
    logic [N-1:0]  ram_wdata, ram_rdata;

    assign wr_in_range  = {1'b0, wr_addr}  < (AW+1)'(DEPTH);
    assign req_in_range = {1'b0, req_addr} < (AW+1)'(DEPTH);

    assign busy      = (state == CLEAR);
    assign req_ready = (state == RUN) && !flush && (!rsp_valid || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign load_wr   = wr_en && (state == LOAD) && wr_in_range;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == CLEAR) ? cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        unique case (state)
            CLEAR: if (cnt == CW'(DEPTH - 1)) state_nxt = load_mode ? LOAD : RUN;
            LOAD:  if (!load_mode)            state_nxt = RUN;
            RUN:   if (load_mode)             state_nxt = LOAD;
            default:                          state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        ram_we    = load_wr;
        ram_waddr = wr_addr[CW-1:0];
        ram_wdata = wr_data;
        if (state == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = cnt;
            ram_wdata = N'(NOP_WORD);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_err    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
        end else begin
            wr_err <= wr_en && !load_wr;
            if (accept) begin
                rsp_valid <= 1'b1;
                rsp_fault <= !req_in_range;
            end else if (flush || rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    // The read register only loads on acceptance, which keeps a stalled response stable.
    imem_ram #(
        .N     (N),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_ram (
        .clk   (clk),
        .rst_n (reset_n),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (accept),
        .raddr (req_addr[CW-1:0]),
        .rdata (ram_rdata)
    );

    assign rsp_data = rsp_fault ? N'(NOP_WORD) : ram_rdata;

endmodule

// File: tb/tb_imem_pipe.sv
// Directed, table-driven bench for imem_pipe.
module tb_imem_pipe;

    localparam int N = 32;
    localparam int DEPTH = 64;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          load_mode = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [N-1:0]  wr_data = '0;
    logic          wr_err;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic          flush = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [N-1:0]  rsp_data;
    logic          rsp_fault;
    logic          busy;

    int n_tests = 0;
    int n_fail = 0;

    imem_pipe #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_mode (load_mode),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_err    (wr_err),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_fault (rsp_fault),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [N-1:0]  data;
        logic          err;
    } wr_vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [N-1:0]  data;
        logic          fault;
    } rd_vec_t;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until busy drops; the CLEAR sweep should take exactly DEPTH edges.
    task automatic wait_clear(input string name);
        int cycles = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            cycles++;
            if (!busy) break;
        end
        check({name, "_cycles"}, N'(cycles), N'(DEPTH));
        check({name, "_busy_done"}, N'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_busy"}, N'(busy), 32'd1);
        check({name, "_rsp_valid"}, N'(rsp_valid), 32'd0);
        check({name, "_rsp_data"}, rsp_data, 32'd0);
        check({name, "_rsp_fault"}, N'(rsp_fault), 32'd0);
        check({name, "_wr_err"}, N'(wr_err), 32'd0);
        check({name, "_req_ready"}, N'(req_ready), 32'd0);
    endtask

    // Back-to-back fetches with rsp_ready held high; one response per cycle.
    task automatic run_fetches(input string name, input rd_vec_t tbl[$]);
        rsp_ready = 1'b1;
        foreach (tbl[i]) begin
            req_valid = 1'b1;
            req_addr  = tbl[i].addr;
            #1;
            check($sformatf("%s_ready_%0d", name, i), N'(req_ready), 32'd1);
            tick();
            check($sformatf("%s_valid_%0d", name, i), N'(rsp_valid), 32'd1);
            check($sformatf("%s_data_%0d", name, i), rsp_data, tbl[i].data);
            check($sformatf("%s_fault_%0d", name, i), N'(rsp_fault), N'(tbl[i].fault));
        end
        req_valid = 1'b0;
        tick();
        check({name, "_drain"}, N'(rsp_valid), 32'd0);
    endtask

    initial begin
        wr_vec_t wr_tbl[$];
        rd_vec_t rd_tbl[$];
        rd_vec_t zero_tbl[$];

        wr_tbl = '{
            '{8'd0,   32'hcb170018, 1'b0},
            '{8'd1,   32'hb4000098, 1'b0},
            '{8'd6,   32'hdeadbeef, 1'b0},
            '{8'd63,  32'h12345678, 1'b0},
            '{8'd64,  32'h55555555, 1'b1},
            '{8'd255, 32'h66666666, 1'b1}
        };
        rd_tbl = '{
            '{8'd0,   32'hcb170018, 1'b0},
            '{8'd1,   32'hb4000098, 1'b0},
            '{8'd5,   32'h00000000, 1'b0},
            '{8'd63,  32'h12345678, 1'b0},
            '{8'd6,   32'hdeadbeef, 1'b0},
            '{8'd64,  32'h00000000, 1'b1},
            '{8'd70,  32'h00000000, 1'b1},
            '{8'd255, 32'h00000000, 1'b1}
        };
        zero_tbl = '{
            '{8'd0,  32'h0, 1'b0},
            '{8'd1,  32'h0, 1'b0},
            '{8'd63, 32'h0, 1'b0}
        };

        // Power-on reset and first CLEAR.
        #1 reset_n = 1'b0;
        #1 check_reset_outputs("por");
        #12 reset_n = 1'b1;
        wait_clear("clear1");
        check("run_ready", N'(req_ready), 32'd1);

        req_valid = 1'b1;
        req_addr  = 8'd5;
        tick();
        req_valid = 1'b0;
        check("fetch5_valid", N'(rsp_valid), 32'd1);
        check("fetch5_data", rsp_data, 32'd0);
        check("fetch5_fault", N'(rsp_fault), 32'd0);
        tick();

        // Writing while in RUN is rejected.
        wr_en = 1'b1;
        wr_addr = 8'd3;
        wr_data = 32'h11111111;
        tick();
        wr_en = 1'b0;
        check("run_wr_err", N'(wr_err), 32'd1);
        tick();
        check("run_wr_err_clr", N'(wr_err), 32'd0);

        // Program load, including out-of-range writes.
        load_mode = 1'b1;
        tick();
        check("load_ready", N'(req_ready), 32'd0);
        foreach (wr_tbl[i]) begin
            wr_en   = 1'b1;
            wr_addr = wr_tbl[i].addr;
            wr_data = wr_tbl[i].data;
            tick();
            wr_en = 1'b0;
            check($sformatf("wr_err_%0d", i), N'(wr_err), N'(wr_tbl[i].err));
            tick();
            check($sformatf("wr_err_pulse_%0d", i), N'(wr_err), 32'd0);
        end
        load_mode = 1'b0;
        tick();
        run_fetches("fetch", rd_tbl);

        // Stall: response held for 3 cycles, then handshake with a new acceptance.
        req_valid = 1'b1;
        req_addr  = 8'd1;
        rsp_ready = 1'b0;
        tick();
        req_addr = 8'd0;
        for (int c = 0; c < 3; c++) begin
            #1 check($sformatf("stall_ready_%0d", c), N'(req_ready), 32'd0);
            tick();
            check($sformatf("stall_valid_%0d", c), N'(rsp_valid), 32'd1);
            check($sformatf("stall_data_%0d", c), rsp_data, 32'hb4000098);
        end
        rsp_ready = 1'b1;
        #1 check("stall_release_ready", N'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        check("stall_next_valid", N'(rsp_valid), 32'd1);
        check("stall_next_data", rsp_data, 32'hcb170018);
        tick();
        check("stall_drain", N'(rsp_valid), 32'd0);

        // Flush drops the pending response and blocks the concurrent request.
        req_valid = 1'b1;
        req_addr  = 8'd1;
        tick();
        rsp_ready = 1'b0;
        flush     = 1'b1;
        req_addr  = 8'd0;
        #1 check("flush_ready", N'(req_ready), 32'd0);
        tick();
        flush = 1'b0;
        req_valid = 1'b0;
        check("flush_valid", N'(rsp_valid), 32'd0);
        tick();
        check("flush_no_accept", N'(rsp_valid), 32'd0);

        // Pending response survives RUN -> LOAD, then reset mid-LOAD.
        req_valid = 1'b1;
        req_addr  = 8'd0;
        tick();
        req_valid = 1'b0;
        load_mode = 1'b1;
        tick();
        check("load_pending_valid", N'(rsp_valid), 32'd1);
        check("load_pending_data", rsp_data, 32'hcb170018);
        wr_en   = 1'b1;
        wr_addr = 8'd100;
        tick();
        wr_en = 1'b0;
        check("pre_reset_wr_err", N'(wr_err), 32'd1);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("mid_load_rst");
        tick();
        rsp_ready = 1'b1;
        load_mode = 1'b0;
        reset_n   = 1'b1;
        wait_clear("clear2");
        run_fetches("cleared", zero_tbl);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
